tt_um_pwm_bank: RTL
===================

TT_UM_PWM_BANK -- requirements
Module: tt_um_pwm_bank

Interface
REQ-001 SHALL have parameter NCH, default 8, number of PWM channels (legal 1..8).
REQ-002 SHALL have parameter WIDTH, default 8, duty/counter width in bits (legal 4..8).
REQ-003 SHALL have parameter RST_PRESC, default 0, reset value of the prescaler divisor.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-006 ena  input  1  design selected; low freezes counters and forces PWM outputs to 0.
REQ-007 ui_in  input  8  [7] wr strobe, [6] sel (0 duty, 1 prescaler), [5] rd (readback), [2:0] channel address; [4:3] unused.
REQ-008 uio_in  input  8  write data; duty uses [WIDTH-1:0], prescaler uses [7:0].
REQ-009 uo_out  output  8  [NCH-1:0] PWM outputs, [7:NCH] tied 0.
REQ-010 uio_out  output  8  readback data (REQ-024), else 0.
REQ-011 uio_oe  output  8  bidir enables, 1 = output.

Function
REQ-012 SHALL register ui_in[7] and perform exactly one write per 0->1 edge, in the cycle after the edge is seen.
REQ-013 Duty write (sel=0) SHALL load shadow duty of channel addr; addr >= NCH ignored.
REQ-014 Prescaler write (sel=1) SHALL load divisor P and clear the prescale counter in the same cycle.
REQ-015 Prescaler SHALL issue one tick every P+1 clocks while ena=1 (P=0 -> every clock).
REQ-016 Period counter cnt (WIDTH bits) SHALL increment per tick and wrap MAX->0, MAX=2^WIDTH-1.
REQ-017 On the tick where cnt wraps MAX->0, every shadow duty SHALL copy into its active duty (glitch-free update).
REQ-018 Shadow write and wrap in the same cycle: the newly written value SHALL be copied.
REQ-019 Channel i output SHALL be registered: high iff active_duty[i]==MAX, or cnt < active_duty[i]; one clock latency from cnt.
REQ-020 Duty 0 -> constantly low; duty MAX -> constantly high; duty d otherwise -> high d of MAX+1 ticks.
REQ-021 ena=0: prescaler, cnt held; uo_out=0 next clock; registers still writable; resumes from held state on ena=1.
REQ-022 uio_oe SHALL be 8'h00 whenever readback is inactive.

Reset
REQ-023 rst_n=0 SHALL asynchronously clear cnt, prescale counter, all shadow/active duties, wr edge register, uo_out, uio_out, uio_oe; P := RST_PRESC; reset mid-period discards pending shadow values.

Configuration
REQ-024 With PWM_READBACK_EN defined: while rd=1 and wr=0, uio_oe=8'hFF and uio_out=zero-extended shadow duty of addr (sel=0) or P (sel=1), registered, 1-cycle latency; addr >= NCH reads 0.
REQ-025 Without PWM_READBACK_EN: rd ignored, uio_out=0 and uio_oe=0 constantly, no readback logic synthesised.

Structure
REQ-026 Shared package pwm_pkg SHALL hold field-position constants for ui_in bits, default NCH/WIDTH, and the sel encoding.
REQ-027 One sub-module pwm_channel (shadow reg, active reg, compare, output flop) SHALL be instantiated NCH times via generate.

Verification
REQ-028 Reset, P=0, write duty 64 to ch0 (WIDTH=8) -> after first wrap ch0 high 64 of every 256 clocks, other channels low.
REQ-029 Write ch1 duty 0 and ch2 duty 255 -> ch1 never high, ch2 never low after next wrap.
REQ-030 Write P=3, ch0 duty 128 -> ch0 period 1024 clocks, high 512.
REQ-031 Change ch0 duty 64->192 mid-period -> current period keeps 64, next period 192; write coincident with wrap -> 192 applies immediately.
REQ-032 Drop ena for 100 clocks mid-period -> uo_out=0, cnt frozen, resumes at same cnt; assert rst_n mid-period -> all outputs 0 immediately, duties 0.
REQ-033 PWM_READBACK_EN build: write ch5 duty 0x5A, rd=1 addr=5 -> uio_oe=FF, uio_out=5A next clock; rd=0 -> uio_oe=00; non-macro build -> uio_oe stays 00.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants for the PWM bank: ui_in field positions, default geometry
// and the register-select encoding.
package pwm_pkg;

    localparam int UI_WR_BIT   = 7;
    localparam int UI_SEL_BIT  = 6;
    localparam int UI_RD_BIT   = 5;
    localparam int UI_ADDR_LSB = 0;
    localparam int UI_ADDR_W   = 3;

    localparam int DEF_NCH   = 8;
    localparam int DEF_WIDTH = 8;

    typedef enum logic {
        SEL_DUTY  = 1'b0,
        SEL_PRESC = 1'b1
    } sel_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow duty register, active duty register loaded on the
// period wrap, comparator against the shared counter and a registered output.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wrap,
    input  logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] shadow_o,
    output logic             pwm_o
);

    localparam logic [WIDTH-1:0] DUTY_MAX = '1;

    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic             pwm_q, pwm_d;

    always_comb begin
        shadow_d = wr_en ? wr_data : shadow_q;
        // A write landing on the wrap cycle is taken straight into the active copy.
        active_d = wrap ? shadow_d : active_q;
        pwm_d    = ena && ((active_q == DUTY_MAX) || (cnt < active_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            active_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
        end
    end

    assign shadow_o = shadow_q;
    assign pwm_o    = pwm_q;

endmodule

// File: rtl/tt_um_pwm_bank.sv
// Bank of NCH PWM channels sharing a prescaler and period counter.
// Optional register readback on uio is built when PWM_READBACK_EN is defined.
module tt_um_pwm_bank
    import pwm_pkg::*;
#(
    parameter int NCH       = DEF_NCH,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int RST_PRESC = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [3:0]       NCH_L   = 4'(NCH);

    logic                 wr_q, wr_d;
    logic                 wr_pulse;
    logic [UI_ADDR_W-1:0] addr;
    sel_e                 sel;
    logic                 addr_ok;
    logic                 duty_wr;
    logic                 presc_wr;

    logic [7:0]       p_q, p_d;
    logic [7:0]       pc_q, pc_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tick;
    logic             wrap;

    logic [WIDTH-1:0] shadow_all [NCH];
    logic [NCH-1:0]   pwm_vec;
    logic [NCH-1:0]   shadow_par;

    assign addr     = ui_in[UI_ADDR_LSB +: UI_ADDR_W];
    assign sel      = sel_e'(ui_in[UI_SEL_BIT]);
    assign addr_ok  = ({1'b0, addr} < NCH_L);
    assign wr_pulse = ui_in[UI_WR_BIT] && !wr_q;
    assign duty_wr  = wr_pulse && (sel == SEL_DUTY) && addr_ok;
    assign presc_wr = wr_pulse && (sel == SEL_PRESC);

    assign tick = ena && (pc_q == p_q);
    assign wrap = tick && (cnt_q == CNT_MAX);

    always_comb begin
        wr_d  = ui_in[UI_WR_BIT];
        p_d   = presc_wr ? uio_in : p_q;
        pc_d  = pc_q;
        // Tick is judged on the old divisor; a new divisor restarts the count.
        if (presc_wr) begin
            pc_d = '0;
        end else if (tick) begin
            pc_d = '0;
        end else if (ena) begin
            pc_d = pc_q + 8'd1;
        end
        cnt_d = tick ? (cnt_q + 1'b1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= 1'b0;
            p_q   <= 8'(RST_PRESC);
            pc_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            p_q   <= p_d;
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            pwm_channel #(
                .WIDTH (WIDTH)
            ) u_ch (
                .clk      (clk),
                .rst_n    (rst_n),
                .ena      (ena),
                .wr_en    (duty_wr && (addr == UI_ADDR_W'(gi))),
                .wr_data  (uio_in[WIDTH-1:0]),
                .wrap     (wrap),
                .cnt      (cnt_q),
                .shadow_o (shadow_all[gi]),
                .pwm_o    (pwm_vec[gi])
            );
            assign shadow_par[gi] = ^shadow_all[gi];
        end
    endgenerate

    always_comb begin
        uo_out          = '0;
        uo_out[NCH-1:0] = pwm_vec;
    end

`ifdef PWM_READBACK_EN
    logic       rd_active;
    logic [7:0] rd_data;
    logic [7:0] uio_out_q, uio_out_d;
    logic [7:0] uio_oe_q, uio_oe_d;

    assign rd_active = ui_in[UI_RD_BIT] && !ui_in[UI_WR_BIT];

    always_comb begin
        rd_data = '0;
        if (sel == SEL_PRESC) begin
            rd_data = p_q;
        end else if (addr_ok) begin
            rd_data[WIDTH-1:0] = shadow_all[addr];
        end
        uio_out_d = rd_active ? rd_data : 8'h00;
        uio_oe_d  = rd_active ? 8'hFF : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uio_out_q <= '0;
            uio_oe_q  <= '0;
        end else begin
            uio_out_q <= uio_out_d;
            uio_oe_q  <= uio_oe_d;
        end
    end

    assign uio_out = uio_out_q;
    assign uio_oe  = uio_oe_q;

    wire unused_ok = &{1'b0, ui_in[4:3], shadow_par};
`else
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    wire unused_ok = &{1'b0, ui_in[5:3], shadow_par};
`endif

endmodule
